dispatch_buffer: RTL
====================

// Module: dispatch_buffer
// PURPOSE
//  Parametrised N-wide in-order instruction buffer between fetch (IF_ID_PACKET groups) and dispatch/decode.
//  Decouples fetch from back-end stalls and enqueues up to WIDTH packets per cycle into a circular FIFO.
//  Releases up to WIDTH packets per cycle, oldest first, limited by ROB/RS/SQ credits.
//  Cuts each dispatch group after a predicted-taken branch or a halt; once a halt is released, output stops until squash.
// PARAMETERS
//  WIDTH  3  lanes per cycle, in and out; lane WIDTH-1 is the oldest
//  DEPTH  8  buffer entries; power of 2, DEPTH >= 2*WIDTH (elaboration assertion)
//  CNT_W  6  width of the credit inputs rob_free/rs_free/sq_free
// PORTS
//  clock           in   1                    system clock
//  reset           in   1                    synchronous, active-low reset
//  squash          in   1                    mispredict/exception flush
//  if_packet_in    in   IF_ID_PACKET[WIDTH]  fetch group; per-lane .valid
//  if_stall        out  1                    1 = fetch group not accepted this cycle
//  rob_free        in   CNT_W                free ROB entries
//  rs_free         in   CNT_W                free RS entries
//  sq_free         in   CNT_W                free SQ entries
//  dis_packet_out  out  IF_ID_PACKET[WIDTH]  released group; oldest in lane WIDTH-1
//  dis_count       out  $clog2(WIDTH+1)      number of valid output lanes
//  occupancy       out  $clog2(DEPTH+1)      registered entry count
//  halted          out  1                    halt has been released; output frozen
// BEHAVIOUR
//  Reset (reset==0 at posedge): head, tail and occupancy go to 0, halted goes to 0.
//   While reset is low: if_stall=1, dis_count=0 and all output .valid=0.
//  if_stall = (DEPTH - occupancy) < WIDTH. It uses the registered count only and ignores this cycle's dequeue.
//   This keeps the path off the credit inputs and makes overflow impossible.
//  Enqueue, when !if_stall && !squash:
//   - scan lanes WIDTH-1 down to 0; valid lanes are written compacted at tail, in order;
//   - lanes younger than the first valid predict_direction==1 lane are dropped.
//  Dequeue limit n = min(occupancy, WIDTH, rob_free, rs_free), then an oldest-first scan from head:
//   - stop before a store (inst[6:0]==7'b0100011) when stores already taken == sq_free;
//   - stop after a predicted-taken branch (the branch is included);
//   - stop after a halt (WFI; the halt is included), and set halted next cycle.
//  Outputs:
//   - dis_packet_out[WIDTH-1-k] = entry head+k for k < dis_count, with .valid=1;
//   - the remaining lanes have .valid=0 and their other fields are don't-care.
//  Release is fire-and-forget: credits gate it, so there is no ready input and the consumer must accept every valid lane.
//  Latency: a packet enqueued at edge t is visible on dis_packet_out in cycle t+1 at the earliest. There is no bypass.
//  Next state: occupancy += enq_cnt - dis_count; head/tail advance modulo DEPTH (natural pointer wrap).
//  Enqueue and dequeue in the same cycle are legal, including across the wrap point.
//  halted==1: dis_count=0. Enqueue continues until the buffer is full.
//  squash has priority over everything:
//   - in that cycle dis_count=0 and no enqueue happens;
//   - next cycle head=tail=occupancy=0 and halted=0.
//  Empty: dis_count=0 and if_stall=0. Full: if_stall=1, and release continues.
//  Any zero credit (rob_free=0 or rs_free=0): dis_count=0, no state change except enqueue.
// STRUCTURE
//  sys_defs package additions:
//   - `OPC_STORE 7'b0100011 and `INST_WFI constants;
//   - function is_store_inst(inst) and function is_halt_inst(inst), shared with the decoder.
//  Sub-module dispatch_lane_select (combinational):
//   - inputs: WIDTH candidate entries plus the credits;
//   - outputs: dis_count, the per-lane valid mask and halt_taken.
//  The top level holds the storage array, pointers, occupancy and the halted flag.
// TESTING
//  1 Reset low for 2 cycles with valid input -> if_stall=1, dis_count=0; after release occupancy=0, if_stall=0.
//  2 3 ALU ops enqueued, credits=8 -> next cycle dis_count=3; oldest op in lane 2; occupancy back to 0.
//  3 Input lanes {2:ALU, 1:taken branch, 0:ALU} -> only 2 entries enqueued.
//    Same order buffered from separate groups -> released group ends at the branch, dis_count=2.
//  4 Buffer holds 3 stores, sq_free=1 -> dis_count=1 per cycle while sq_free stays 1.
//    rob_free=2, rs_free=5 with 3 ALU ops -> dis_count=2.
//  5 Fill to 8 with output credits 0 -> if_stall=1, occupancy=8.
//    Then credits=8 with new input each cycle -> sustained 3-in/3-out across the pointer wrap, FIFO order preserved.
//  6 WFI in the middle of 6 entries -> released up to and including WFI; halted=1, dis_count=0 afterwards.
//    squash -> next cycle occupancy=0, halted=0; the squash cycle itself has dis_count=0.

Source files
------------

// File: rtl/dispatch_buffer_pkg.sv
// Shared types and instruction helpers for the fetch-to-dispatch buffer.
package dispatch_buffer_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [6:0]      OPC_STORE = 7'b0100011;
    localparam logic [ILEN-1:0] INST_WFI  = 32'h1050_0073;

    typedef struct packed {
        logic            valid;
        logic            predict_direction;
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } if_id_packet_t;

    function automatic logic is_store_inst(input logic [ILEN-1:0] inst);
        return inst[6:0] == OPC_STORE;
    endfunction

    function automatic logic is_halt_inst(input logic [ILEN-1:0] inst);
        return inst == INST_WFI;
    endfunction

endpackage

// File: rtl/dispatch_buffer_if.sv
// Fetch-side and dispatch-side signals of the dispatch buffer.
interface dispatch_buffer_if #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 6
);
    import dispatch_buffer_pkg::*;

    logic                              squash;
    if_id_packet_t [WIDTH-1:0]         if_packet_in;
    logic                              if_stall;
    logic [CNT_W-1:0]                  rob_free;
    logic [CNT_W-1:0]                  rs_free;
    logic [CNT_W-1:0]                  sq_free;
    if_id_packet_t [WIDTH-1:0]         dis_packet_out;
    logic [$clog2(WIDTH+1)-1:0]        dis_count;
    logic [$clog2(DEPTH+1)-1:0]        occupancy;
    logic                              halted;

    modport master (
        output squash, if_packet_in, rob_free, rs_free, sq_free,
        input  if_stall, dis_packet_out, dis_count, occupancy, halted
    );

    modport slave (
        input  squash, if_packet_in, rob_free, rs_free, sq_free,
        output if_stall, dis_packet_out, dis_count, occupancy, halted
    );

endinterface

// File: rtl/dispatch_lane_select.sv
// Picks how many of the oldest buffered entries can be released this cycle,
// given credits and the group-cutting rules for stores, taken branches and halts.
module dispatch_lane_select
    import dispatch_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned OCC_W = 4,
    parameter int unsigned CNT_W = 6
) (
    input  logic [WIDTH-1:0][ILEN-1:0]  cand_inst,
    input  logic [WIDTH-1:0]            cand_taken,
    input  logic [OCC_W-1:0]            occupancy,
    input  logic [CNT_W-1:0]            rob_free,
    input  logic [CNT_W-1:0]            rs_free,
    input  logic [CNT_W-1:0]            sq_free,
    output logic [$clog2(WIDTH+1)-1:0]  dis_count_c,
    output logic [WIDTH-1:0]            lane_mask_c,
    output logic                        halt_taken_c
);

    localparam int unsigned DC_W  = $clog2(WIDTH + 1);
    localparam int unsigned LIM_W = (CNT_W > OCC_W) ? CNT_W : OCC_W;

    logic [LIM_W-1:0] limit;
    logic [CNT_W-1:0] stores_taken;
    logic             stop;
    logic             st;
    logic             hlt;

    // Upper bound from buffer contents, lane count and ROB/RS credits.
    always_comb begin
        limit = LIM_W'(occupancy);
        if (LIM_W'(WIDTH) < limit)    limit = LIM_W'(WIDTH);
        if (LIM_W'(rob_free) < limit) limit = LIM_W'(rob_free);
        if (LIM_W'(rs_free) < limit)  limit = LIM_W'(rs_free);
    end

    // Oldest-first scan; cand index k is the k-th oldest entry.
    always_comb begin
        dis_count_c  = '0;
        lane_mask_c  = '0;
        halt_taken_c = 1'b0;
        stores_taken = '0;
        stop         = 1'b0;
        st           = 1'b0;
        hlt          = 1'b0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            st  = is_store_inst(cand_inst[k]);
            hlt = is_halt_inst(cand_inst[k]);
            if (!stop && (LIM_W'(k) < limit)) begin
                if (st && (stores_taken == sq_free)) begin
                    stop = 1'b1;
                end else begin
                    lane_mask_c[k] = 1'b1;
                    dis_count_c    = dis_count_c + DC_W'(1);
                    if (st)                 stores_taken = stores_taken + CNT_W'(1);
                    if (cand_taken[k] || hlt) stop = 1'b1;
                    if (hlt)                halt_taken_c = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dispatch_buffer.sv
// In-order circular buffer between fetch and dispatch: compacting enqueue of up to
// WIDTH packets, credit-limited oldest-first release, halt freeze and squash flush.
module dispatch_buffer
    import dispatch_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 6
) (
    input  logic           clock,
    input  logic           reset,
    dispatch_buffer_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned DC_W  = $clog2(WIDTH + 1);

    if ((DEPTH < 2 * WIDTH) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_params
        $error("dispatch_buffer: DEPTH must be a power of 2 and at least 2*WIDTH");
    end

    if_id_packet_t             mem_q [DEPTH];
    if_id_packet_t             mem_d [DEPTH];
    logic [PTR_W-1:0]          head_q, head_d;
    logic [PTR_W-1:0]          tail_q, tail_d;
    logic [OCC_W-1:0]          occupancy_q, occupancy_d;
    logic                      halted_q, halted_d;

    if_id_packet_t [WIDTH-1:0] cand;
    logic [WIDTH-1:0][ILEN-1:0] cand_inst;
    logic [WIDTH-1:0]          cand_taken;
    logic [DC_W-1:0]           sel_count;
    logic [WIDTH-1:0]          sel_mask;
    logic                      sel_halt;
    logic                      dis_en;
    logic                      enq_en;
    logic                      if_stall_c;
    logic [DC_W-1:0]           dis_count_c;
    logic [DC_W-1:0]           enq_cnt;
    logic                      enq_cut;
    if_id_packet_t [WIDTH-1:0] dis_out;

    // Stall decision looks only at the registered count, never at this cycle's release.
    assign if_stall_c  = !reset || ((OCC_W'(DEPTH) - occupancy_q) < OCC_W'(WIDTH));
    assign enq_en      = !if_stall_c && !bus.squash;
    assign dis_en      = reset && !bus.squash && !halted_q;
    assign dis_count_c = dis_en ? sel_count : '0;

    always_comb begin
        for (int unsigned k = 0; k < WIDTH; k++) begin
            cand[k]       = mem_q[head_q + PTR_W'(k)];
            cand_inst[k]  = cand[k].inst;
            cand_taken[k] = cand[k].predict_direction;
        end
    end

    dispatch_lane_select #(
        .WIDTH (WIDTH),
        .OCC_W (OCC_W),
        .CNT_W (CNT_W)
    ) u_lane_select (
        .cand_inst    (cand_inst),
        .cand_taken   (cand_taken),
        .occupancy    (occupancy_q),
        .rob_free     (bus.rob_free),
        .rs_free      (bus.rs_free),
        .sq_free      (bus.sq_free),
        .dis_count_c  (sel_count),
        .lane_mask_c  (sel_mask),
        .halt_taken_c (sel_halt)
    );

    // Compacting enqueue, oldest lane first; younger lanes after a predicted-taken branch are dropped.
    always_comb begin
        mem_d   = mem_q;
        enq_cnt = '0;
        enq_cut = 1'b0;
        if (enq_en) begin
            for (int l = int'(WIDTH) - 1; l >= 0; l--) begin
                if (!enq_cut && bus.if_packet_in[l].valid) begin
                    mem_d[tail_q + PTR_W'(enq_cnt)] = bus.if_packet_in[l];
                    enq_cnt = enq_cnt + DC_W'(1);
                    enq_cut = bus.if_packet_in[l].predict_direction;
                end
            end
        end
    end

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        occupancy_d = occupancy_q;
        halted_d    = halted_q;
        if (bus.squash) begin
            head_d      = '0;
            tail_d      = '0;
            occupancy_d = '0;
            halted_d    = 1'b0;
        end else begin
            head_d      = head_q + PTR_W'(dis_count_c);
            tail_d      = tail_q + PTR_W'(enq_cnt);
            occupancy_d = occupancy_q + OCC_W'(enq_cnt) - OCC_W'(dis_count_c);
            halted_d    = halted_q | (dis_en & sel_halt);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            occupancy_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            occupancy_q <= occupancy_d;
            halted_q    <= halted_d;
        end
    end

    // Payload storage needs no reset; occupancy alone defines which entries are live.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    // Oldest released entry lands in the top lane.
    always_comb begin
        for (int unsigned k = 0; k < WIDTH; k++) begin
            dis_out[WIDTH-1-k]       = cand[k];
            dis_out[WIDTH-1-k].valid = dis_en & sel_mask[k];
        end
    end

    assign bus.if_stall       = if_stall_c;
    assign bus.dis_packet_out = dis_out;
    assign bus.dis_count      = dis_count_c;
    assign bus.occupancy      = occupancy_q;
    assign bus.halted         = halted_q;

endmodule
